wb_regfile: RTL and testbench

- Writeback-stage consumer of the MEM/WB pipeline register outputs. Holds the 8 x 8-bit architectural register file.
- Normal instructions: selects the writeback result (ALU or memory) and writes it to the register file.
- Matrix-multiply instructions: sequences a 4-beat result burst from the matrix unit into 4 consecutive registers, stalling the pipeline for the burst.
- Provides two decode-stage read ports with same-cycle write bypass.

---
 rtl/wb_regfile_if.sv | 36 +++
 rtl/wb_regfile.sv | 112 +++++++++++
 tb/tb_wb_regfile.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/wb_regfile_if.sv
// MEM/WB-to-writeback bundle: pipeline inputs, matrix-unit beat handshake,
// decode read ports and stall/done status.
interface wb_regfile_if #(
  parameter int DW = 8,
  parameter int AW = 3
);
  logic [DW-1:0] ReadData_in;
  logic [DW-1:0] ALUResult_in;
  logic [AW-1:0] destreg_in;
  logic          RegWrite_in;
  logic          ResultSrc_in;
  logic          is_matrix_mult_in;
  // A matrix beat transfers on a cycle where mm_valid and mm_ready are both high;
  // mm_valid may rise or fall freely, and a low mm_valid simply holds the burst.
  logic          mm_valid;
  logic [DW-1:0] mm_data;
  logic          mm_ready;
  logic [AW-1:0] rs1_addr;
  logic [AW-1:0] rs2_addr;
  logic [DW-1:0] rs1_data;
  logic [DW-1:0] rs2_data;
  logic          stall_out;
  logic          mm_done;

  modport master (
    output ReadData_in, ALUResult_in, destreg_in, RegWrite_in, ResultSrc_in,
           is_matrix_mult_in, mm_valid, mm_data, rs1_addr, rs2_addr,
    input  mm_ready, rs1_data, rs2_data, stall_out, mm_done
  );

  modport slave (
    input  ReadData_in, ALUResult_in, destreg_in, RegWrite_in, ResultSrc_in,
           is_matrix_mult_in, mm_valid, mm_data, rs1_addr, rs2_addr,
    output mm_ready, rs1_data, rs2_data, stall_out, mm_done
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage: architectural register file with normal writeback,
// stalled matrix-multiply result bursts and bypassed decode read ports.
module wb_regfile #(
  parameter int DW       = 8,
  parameter int NREG     = 8,
  parameter int MM_BEATS = 4
) (
  input  logic       clk,
  input  logic       reset,
  wb_regfile_if.slave bus,
  output logic [1:0] dbg_state_o
);
  localparam int AW = $clog2(NREG);
  localparam int CW = $clog2(MM_BEATS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MM_WRITE = 2'd1,
    S_MM_DONE  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   base_q, base_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   regs_q [NREG];

  logic            we;
  logic [AW-1:0]   waddr;
  logic [DW-1:0]   wdata;
  logic [DW-1:0]   wb_data;

  assign wb_data     = bus.ResultSrc_in ? bus.ReadData_in : bus.ALUResult_in;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      base_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    cnt_d         = cnt_q;
    we            = 1'b0;
    waddr         = '0;
    wdata         = '0;
    bus.stall_out = 1'b0;
    bus.mm_ready  = 1'b0;
    bus.mm_done   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.RegWrite_in) begin
          if (bus.is_matrix_mult_in) begin
            bus.stall_out = 1'b1;
            base_d        = bus.destreg_in;
            cnt_d         = '0;
            state_d       = S_MM_WRITE;
          end else begin
            we    = 1'b1;
            waddr = bus.destreg_in;
            wdata = wb_data;
          end
        end
      end
      S_MM_WRITE: begin
        bus.stall_out = 1'b1;
        bus.mm_ready  = 1'b1;
        if (bus.mm_valid) begin
          we    = 1'b1;
          // Burst addresses wrap modulo the register count; beats aimed at R0 still count.
          waddr = base_q + AW'(cnt_q);
          wdata = bus.mm_data;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(MM_BEATS - 1)) state_d = S_MM_DONE;
        end
      end
      S_MM_DONE: begin
        // MEM/WB still holds the matrix instruction here; ignoring it avoids a re-trigger.
        bus.mm_done = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (we && (waddr != '0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    bus.rs1_data = regs_q[bus.rs1_addr];
    if (bus.rs1_addr == '0)                   bus.rs1_data = '0;
    else if (we && (waddr == bus.rs1_addr))   bus.rs1_data = wdata;
  end

  always_comb begin
    bus.rs2_data = regs_q[bus.rs2_addr];
    if (bus.rs2_addr == '0)                   bus.rs2_data = '0;
    else if (we && (waddr == bus.rs2_addr))   bus.rs2_data = wdata;
  end
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed plan followed by random traffic, checked
// against a register-array / beats-remaining reference model.
module tb_wb_regfile;
  logic       clk;
  logic       reset;
  logic [1:0] dbg_state;

  wb_regfile_if #(.DW(8), .AW(3)) bus ();

  wb_regfile #(.DW(8), .NREG(8), .MM_BEATS(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // expected = {rs1_data, rs2_data, stall_out, mm_ready, mm_done}
  logic [18:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [7:0] m_regs [8];
  int         m_left;
  int         m_addr;
  bit         m_done_pend;

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, got, exp);
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      e = exp_q.pop_front();
      check("rs1_data",  bus.rs1_data,         e[18:11]);
      check("rs2_data",  bus.rs2_data,         e[10:3]);
      check("stall_out", {7'd0, bus.stall_out}, {7'd0, e[2]});
      check("mm_ready",  {7'd0, bus.mm_ready},  {7'd0, e[1]});
      check("mm_done",   {7'd0, bus.mm_done},   {7'd0, e[0]});
    end
  end

  function automatic logic [7:0] exp_read(input logic [2:0] a, input bit we,
                                          input int wa, input logic [7:0] wd);
    if (a == 3'd0)            return 8'h00;
    if (we && (wa == int'(a))) return wd;
    return m_regs[a];
  endfunction

  // One clock cycle: apply inputs, predict outputs, advance model after the edge.
  task automatic step(input bit rst, input bit rw, input bit rs, input bit mm,
                      input logic [7:0] rd, input logic [7:0] alu, input logic [2:0] dest,
                      input bit v, input logic [7:0] md,
                      input logic [2:0] a1, input logic [2:0] a2);
    bit we = 0, e_stall = 0, e_ready = 0, e_done = 0;
    int wa = 0;
    int phase;
    logic [7:0] wd = 8'h00;
    reset                 = rst;
    bus.RegWrite_in       = rw;
    bus.ResultSrc_in      = rs;
    bus.is_matrix_mult_in = mm;
    bus.ReadData_in       = rd;
    bus.ALUResult_in      = alu;
    bus.destreg_in        = dest;
    bus.mm_valid          = v;
    bus.mm_data           = md;
    bus.rs1_addr          = a1;
    bus.rs2_addr          = a2;
    if (!rst) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
      m_left = 0; m_done_pend = 0; phase = 0;
    end else if (m_done_pend) begin
      e_done = 1; phase = 1;
    end else if (m_left > 0) begin
      e_stall = 1; e_ready = 1; phase = 2;
      if (v) begin we = 1; wa = m_addr; wd = md; end
    end else if (rw && mm) begin
      e_stall = 1; phase = 3;
    end else if (rw) begin
      we = 1; wa = dest; wd = rs ? rd : alu; phase = 4;
    end else begin
      phase = 5;
    end
    exp_q.push_back({exp_read(a1, we, wa, wd), exp_read(a2, we, wa, wd),
                     e_stall, e_ready, e_done});
    @(posedge clk);
    #1;
    if (we && wa != 0) m_regs[wa] = wd;
    case (phase)
      1: m_done_pend = 0;
      2: if (v) begin
           m_addr = (m_addr + 1) % 8;
           m_left--;
           if (m_left == 0) m_done_pend = 1;
         end
      3: begin m_left = 4; m_addr = int'(dest); end
      default: ;
    endcase
  endtask

  task automatic idle_read(input logic [2:0] a1, input logic [2:0] a2);
    step(1, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00, a1, a2);
  endtask

  task automatic mm_beat(input logic [7:0] md, input logic [2:0] base,
                         input logic [2:0] a1, input logic [2:0] a2);
    step(1, 1, 0, 1, 8'h00, 8'h00, base, 1, md, a1, a2);
  endtask

  initial begin
    reset = 1'b0;
    bus.RegWrite_in = 0; bus.ResultSrc_in = 0; bus.is_matrix_mult_in = 0;
    bus.ReadData_in = 0; bus.ALUResult_in = 0; bus.destreg_in = 0;
    bus.mm_valid = 0; bus.mm_data = 0; bus.rs1_addr = 0; bus.rs2_addr = 0;
    for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
    m_left = 0; m_addr = 0; m_done_pend = 0;
    @(posedge clk); #1;

    step(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 3'd2, 3'd5);
    step(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 3'd7, 3'd1);

    // normal write with same-cycle bypass, then array read
    step(1, 1, 0, 0, 8'h00, 8'h3C, 3'd2, 0, 8'h00, 3'd2, 3'd0);
    idle_read(3'd2, 3'd5);
    // load, then write to R0 discarded
    step(1, 1, 1, 0, 8'hA5, 8'h00, 3'd5, 0, 8'h00, 3'd5, 3'd2);
    step(1, 1, 0, 0, 8'h00, 8'hFF, 3'd0, 0, 8'h00, 3'd0, 3'd5);
    idle_read(3'd0, 3'd5);

    // matrix burst at R3 with a gap after beat 2; stalled normal write to R7 ignored
    step(1, 1, 0, 1, 8'h00, 8'h00, 3'd3, 0, 8'h00, 3'd3, 3'd4);
    mm_beat(8'h11, 3'd3, 3'd3, 3'd4);
    mm_beat(8'h22, 3'd3, 3'd4, 3'd3);
    step(1, 1, 0, 0, 8'h00, 8'h99, 3'd7, 0, 8'h00, 3'd7, 3'd5);
    mm_beat(8'h33, 3'd3, 3'd5, 3'd7);
    mm_beat(8'h44, 3'd3, 3'd6, 3'd7);
    step(1, 1, 0, 1, 8'h00, 8'h00, 3'd3, 0, 8'h00, 3'd3, 3'd7);
    idle_read(3'd4, 3'd5);
    idle_read(3'd6, 3'd7);

    // wrapping burst at R6
    step(1, 1, 0, 1, 8'h00, 8'h00, 3'd6, 0, 8'h00, 3'd6, 3'd7);
    mm_beat(8'h01, 3'd6, 3'd6, 3'd7);
    mm_beat(8'h02, 3'd6, 3'd7, 3'd0);
    mm_beat(8'h03, 3'd6, 3'd0, 3'd1);
    mm_beat(8'h04, 3'd6, 3'd1, 3'd0);
    step(1, 1, 0, 1, 8'h00, 8'h00, 3'd6, 0, 8'h00, 3'd6, 3'd7);
    idle_read(3'd6, 3'd7);
    idle_read(3'd0, 3'd1);

    // reset mid-burst after beat 2
    step(1, 1, 0, 1, 8'h00, 8'h00, 3'd1, 0, 8'h00, 3'd1, 3'd2);
    mm_beat(8'hAA, 3'd1, 3'd1, 3'd2);
    mm_beat(8'hBB, 3'd1, 3'd2, 3'd1);
    step(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 3'd1, 3'd2);
    step(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00, 3'd3, 3'd5);
    idle_read(3'd1, 3'd2);
    idle_read(3'd3, 3'd6);

    // random traffic; resets only with quiet inputs
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        step(0, 0, 0, 0, 8'h00, 8'h00, 3'd0, 0, 8'h00,
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end else begin
        step(1, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
             ($urandom_range(0, 3) == 0),
             8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)),
             bit'($urandom_range(0, 1)), 8'($urandom),
             3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      end
    end
    idle_read(3'd1, 3'd2);

    @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL exp_q_drain got=%0d expected=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
